// File: rtl/vfr_bank_scheduler_if.sv
// vfr_bank_scheduler_if
//   Groups the handshake and bus signals of the frame-reader bank scheduler.
//   desc_*      : frame descriptor hand-over from the producer (valid/ready)
//   released_*  : one-cycle notification that a displayed buffer was retired
//   av_*        : write-only Avalon-MM master into the reader's control slave,
//                 plus the reader's level interrupt
//   Modports: master = scheduler side, slave = producer/reader side.
interface vfr_bank_scheduler_if;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] desc_base;
  logic [15:0] desc_width;
  logic [15:0] desc_height;
  logic        released_valid;
  logic [31:0] released_base;
  logic [4:0]  av_address;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_irq;

  modport master (
    input  desc_valid, desc_base, desc_width, desc_height, av_irq,
    output desc_ready, released_valid, released_base,
           av_address, av_write, av_writedata
  );

  modport slave (
    output desc_valid, desc_base, desc_width, desc_height, av_irq,
    input  desc_ready, released_valid, released_base,
           av_address, av_write, av_writedata
  );
endinterface

// File: rtl/vfr_bank_scheduler.sv
// vfr_bank_scheduler
//   Drives the video frame reader's control slave so a producer can hand over
//   finished frame buffers. Each accepted descriptor fills the reader's
//   inactive register bank, flips the next-bank pointer and (when the reader
//   is not yet running) sets go. Frame-complete interrupts are cleared here and
//   a swap that took effect is reported as a released buffer.
// Ports:
//   clock, reset : block clock, asynchronous active-high reset
//   bus          : vfr_bank_scheduler_if.master (descriptor, release, Avalon)
//   stop         : level request to halt the reader (sampled in RUN)
//   running      : high while go is set by this block
//   frames_shown, repeats : interrupt statistics, only when the macro
//                  VFR_BANK_SCHED_STATS_EN is defined
// Parameters:
//   PIXELS_PER_WORD_LOG2 : log2 of pixels per memory word
//   CTRL_INTERLACED      : value written to both banks' interlaced register
module vfr_bank_scheduler #(
  parameter int         PIXELS_PER_WORD_LOG2 = 3,
  parameter logic [3:0] CTRL_INTERLACED      = 4'd0
) (
  input  logic clock,
  input  logic reset,
  vfr_bank_scheduler_if.master bus,
  input  logic stop,
  output logic running
`ifdef VFR_BANK_SCHED_STATS_EN
  ,
  output logic [15:0] frames_shown,
  output logic [15:0] repeats
`endif
);

  typedef enum logic [3:0] {
    IDLE, CALC, WR_BANK, WR_NEXT, WR_GO, RUN, CLR_IRQ, CLR_WAIT, WR_STOP
  } state_t;

  localparam logic [32:0] WORD_RND = 33'((64'd1 << PIXELS_PER_WORD_LOG2) - 64'd1);

  state_t      state, state_d;
  logic [2:0]  seq, seq_d;
  logic        ready_en;
  logic        pending;
  logic        irq_seen;
  logic        active_bank;
  logic        target_bank;
  logic        accept;
  logic        service;
  logic        wr_d;
  logic [4:0]  addr_d;
  logic [31:0] data_d;

  logic [31:0] d_base;
  logic [15:0] d_width;
  logic [15:0] d_height;
  logic [31:0] samples_p0;
  logic [31:0] words_p0;
  logic [31:0] active_base;
  logic [31:0] pending_base;

  // Word count rounds up; the 33-bit sum keeps the carry of the rounding add.
  function automatic logic [31:0] ceil_words(input logic [31:0] s);
    logic [32:0] t;
    t = ({1'b0, s} + WORD_RND) >> PIXELS_PER_WORD_LOG2;
    return t[31:0];
  endfunction

  // Bank register order skips the unused slot after samples (addr 7 / 14).
  function automatic logic [4:0] bank_addr(input logic bank, input logic [2:0] idx);
    logic [4:0] off;
    off = (idx < 3'd3) ? {2'b00, idx} : {2'b00, idx} + 5'd1;
    return (bank ? 5'd11 : 5'd4) + off;
  endfunction

  // Ready is suppressed in the RUN cycle that honours stop so a descriptor
  // can never be accepted and then dropped by the halt.
  assign bus.desc_ready = ready_en &&
                          ((state == IDLE) || (state == RUN && !pending && !stop));
  assign accept = bus.desc_valid && bus.desc_ready;

  always_comb begin
    state_d = state;
    seq_d   = seq;
    wr_d    = 1'b0;
    addr_d  = 5'd0;
    data_d  = 32'd0;
    service = 1'b0;
    unique case (state)
      IDLE:    if (accept) state_d = CALC;
      CALC:    state_d = WR_BANK;
      WR_BANK: begin
        wr_d   = 1'b1;
        addr_d = bank_addr(target_bank, seq);
        case (seq)
          3'd0:    data_d = d_base;
          3'd1:    data_d = words_p0;
          3'd2:    data_d = samples_p0;
          3'd3:    data_d = {16'd0, d_width};
          3'd4:    data_d = {16'd0, d_height};
          default: data_d = {28'd0, CTRL_INTERLACED};
        endcase
        if (seq == 3'd5) begin
          seq_d   = 3'd0;
          state_d = WR_NEXT;
        end else begin
          seq_d = seq + 3'd1;
        end
      end
      WR_NEXT: begin
        wr_d    = 1'b1;
        addr_d  = 5'd3;
        data_d  = {31'd0, target_bank};
        state_d = running ? RUN : WR_GO;
      end
      WR_GO: begin
        wr_d    = 1'b1;
        addr_d  = 5'd0;
        data_d  = 32'd3;
        state_d = RUN;
      end
      RUN: begin
        if (stop) begin
          state_d = WR_STOP;
        end else if (accept) begin
          state_d = CALC;
        end else if (bus.av_irq || irq_seen) begin
          state_d = CLR_IRQ;
          service = 1'b1;
        end
      end
      CLR_IRQ: begin
        wr_d    = 1'b1;
        addr_d  = 5'd2;
        data_d  = 32'd1;
        state_d = CLR_WAIT;
      end
      // Blanking cycle: the irq level is still high until the clear lands.
      CLR_WAIT: state_d = RUN;
      WR_STOP: begin
        wr_d    = 1'b1;
        addr_d  = 5'd0;
        data_d  = 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      seq                <= 3'd0;
      ready_en           <= 1'b0;
      running            <= 1'b0;
      pending            <= 1'b0;
      irq_seen           <= 1'b0;
      active_bank        <= 1'b0;
      target_bank        <= 1'b0;
      bus.released_valid <= 1'b0;
      bus.released_base  <= 32'd0;
      bus.av_write       <= 1'b0;
      bus.av_address     <= 5'd0;
      bus.av_writedata   <= 32'd0;
    end else begin
      state              <= state_d;
      seq                <= seq_d;
      ready_en           <= 1'b1;
      bus.released_valid <= 1'b0;
      bus.av_write       <= wr_d;
      bus.av_address     <= addr_d;
      bus.av_writedata   <= data_d;
      if (accept && state == IDLE) begin
        target_bank <= 1'b0;
        active_bank <= 1'b0;
      end
      if (accept && state == RUN) begin
        target_bank <= ~active_bank;
        // Descriptor wins over a coincident irq; remember the irq for later.
        if (bus.av_irq) irq_seen <= 1'b1;
      end
      if ((state == CALC || state == WR_BANK || state == WR_NEXT) && bus.av_irq)
        irq_seen <= 1'b1;
      // The swap only counts once the next-bank pointer is in the reader.
      if (state == WR_NEXT && running) pending <= 1'b1;
      if (state == WR_GO) running <= 1'b1;
      if (service) begin
        irq_seen <= 1'b0;
        if (pending) begin
          bus.released_valid <= 1'b1;
          bus.released_base  <= active_base;
          active_bank        <= ~active_bank;
          pending            <= 1'b0;
        end
      end
      if (state == RUN && stop) begin
        pending  <= 1'b0;
        irq_seen <= 1'b0;
      end
      if (state == WR_STOP) running <= 1'b0;
    end
  end

  // ---- descriptor capture / CALC stage (_p0) ----
  always_ff @(posedge clock) begin
    if (accept) begin
      d_base   <= bus.desc_base;
      d_width  <= bus.desc_width;
      d_height <= bus.desc_height;
    end
    if (accept && state == IDLE) active_base  <= bus.desc_base;
    if (accept && state == RUN)  pending_base <= bus.desc_base;
    if (service && pending)      active_base  <= pending_base;
    if (state == CALC) begin
      samples_p0 <= 32'(d_width) * 32'(d_height);
      words_p0   <= ceil_words(32'(d_width) * 32'(d_height));
    end
  end

`ifdef VFR_BANK_SCHED_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frames_shown <= 16'd0;
      repeats      <= 16'd0;
    end else if (state == WR_STOP) begin
      frames_shown <= 16'd0;
      repeats      <= 16'd0;
    end else if (service) begin
      frames_shown <= frames_shown + 16'd1;
      if (!pending && repeats != 16'hFFFF) repeats <= repeats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vfr_bank_scheduler.sv
module tb_vfr_bank_scheduler;
  localparam int P = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stop  = 1'b0;
  logic running;
`ifdef VFR_BANK_SCHED_STATS_EN
  logic [15:0] frames_shown;
  logic [15:0] repeats;
`endif

  vfr_bank_scheduler_if bus ();

  vfr_bank_scheduler #(
    .PIXELS_PER_WORD_LOG2(P),
    .CTRL_INTERLACED(4'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .stop(stop),
    .running(running)
`ifdef VFR_BANK_SCHED_STATS_EN
    ,
    .frames_shown(frames_shown),
    .repeats(repeats)
`endif
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int run_rise = -1;
  logic run_prev = 1'b0;

  logic [36:0] wr_q[$];
  int          wr_cyc[$];
  logic [31:0] rel_q[$];
  logic [36:0] exp_q[$];
  logic [31:0] rel_exp[$];

  // Reference model: which bank is shown, its buffer, and a queued swap.
  logic        m_bank;
  logic [31:0] m_base;
  bit          m_pending;
  logic [31:0] m_pbase;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.av_write === 1'b1) begin
        wr_q.push_back({bus.av_address, bus.av_writedata});
        wr_cyc.push_back(cyc);
      end
      if (bus.released_valid === 1'b1) rel_q.push_back(bus.released_base);
      if (running === 1'b1 && run_prev !== 1'b1) run_rise = cyc;
    end
    run_prev = running;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic push_bank(input logic bank, input logic [31:0] base,
                           input logic [15:0] w, input logic [15:0] h);
    longint s;
    logic [31:0] d[6];
    int a[6];
    s = longint'(w) * longint'(h);
    d[0] = base;
    d[1] = 32'((s + (longint'(1) << P) - 1) >> P);
    d[2] = 32'(s);
    d[3] = {16'h0, w};
    d[4] = {16'h0, h};
    d[5] = 32'h0;
    if (bank) a = '{11, 12, 13, 15, 16, 17};
    else      a = '{4, 5, 6, 8, 9, 10};
    for (int i = 0; i < 6; i++) exp_q.push_back({5'(a[i]), d[i]});
  endtask

  task automatic model_start(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h);
    push_bank(1'b0, base, w, h);
    exp_q.push_back({5'd3, 32'd0});
    exp_q.push_back({5'd0, 32'd3});
    m_bank = 1'b0; m_base = base; m_pending = 0;
  endtask

  task automatic model_swap(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h);
    push_bank(~m_bank, base, w, h);
    exp_q.push_back({5'd3, 31'd0, ~m_bank});
    m_pending = 1; m_pbase = base;
  endtask

  task automatic model_irq();
    exp_q.push_back({5'd2, 32'd1});
    if (m_pending) begin
      rel_exp.push_back(m_base);
      m_base = m_pbase; m_bank = ~m_bank; m_pending = 0;
    end
  endtask

  task automatic send_desc(input logic [31:0] base, input logic [15:0] w, input logic [15:0] h,
                           input bit with_irq, output bit ok);
    ok = 1'b0;
    @(negedge clock);
    bus.desc_base = base; bus.desc_width = w; bus.desc_height = h;
    bus.desc_valid = 1'b1;
    if (with_irq) bus.av_irq = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.desc_ready === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) begin
      @(posedge clock); #1;
      acc_cyc = cyc;
    end
    bus.desc_valid = 1'b0;
  endtask

  // Holds the reader irq high until the clear write is observed.
  task automatic irq_service(input bit already_high, output bit ok);
    ok = 1'b0;
    if (!already_high) begin
      @(negedge clock);
      bus.av_irq = 1'b1;
    end
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clock);
      if (bus.av_write === 1'b1 && bus.av_address === 5'd2) ok = 1'b1;
    end
    bus.av_irq = 1'b0;
  endtask

  task automatic test_reset();
    bus.desc_valid = 1'b0; bus.desc_base = '0; bus.desc_width = '0; bus.desc_height = '0;
    bus.av_irq = 1'b0; stop = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (bus.desc_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 0", bus.desc_ready);
    end
    vectors++;
    if ({bus.av_write, bus.av_address, bus.av_writedata} !== 38'h0) begin
      miscompares++;
      $display("FAIL reset_av: got w=%b a=%0d d=0x%08h expected all 0",
               bus.av_write, bus.av_address, bus.av_writedata);
    end
    vectors++;
    if ({running, bus.released_valid, bus.released_base} !== 34'h0) begin
      miscompares++;
      $display("FAIL reset_status: got run=%b rv=%b rb=0x%08h expected all 0",
               running, bus.released_valid, bus.released_base);
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.desc_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_ready: got %b expected 1", bus.desc_ready);
    end
  endtask

  task automatic test_first_frame();
    int wb, rb, n;
    bit ok;
    exp_q.delete(); rel_exp.delete();
    wb = wr_q.size(); rb = rel_q.size();
    send_desc(32'h1000, 16'd640, 16'd480, 1'b0, ok);
    model_start(32'h1000, 16'd640, 16'd480);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL first_accept: got no accept, expected accept"); end
    repeat (14) @(negedge clock);
    n = wr_q.size() - wb;
    vectors++;
    if (n != exp_q.size()) begin
      miscompares++; $display("FAIL first_count: got %0d writes expected %0d", n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (wr_q[wb+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL first_wr%0d: got (%0d,0x%08h) expected (%0d,0x%08h)", i,
                 wr_q[wb+i][36:32], wr_q[wb+i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    vectors++;
    if (n < 8 || wr_cyc[wb] - acc_cyc != 2 || wr_cyc[wb+6] - acc_cyc != 8 ||
        wr_cyc[wb+7] - acc_cyc != 9) begin
      miscompares++;
      $display("FAIL first_timing: got %0d writes, first at +%0d, expected +2/+8/+9",
               n, (n > 0) ? wr_cyc[wb] - acc_cyc : -1);
    end
    vectors++;
    if (run_rise - acc_cyc != 9) begin
      miscompares++; $display("FAIL running_rise: got +%0d expected +9", run_rise - acc_cyc);
    end
    vectors++;
    if (running !== 1'b1 || bus.desc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL run_state: got running=%b ready=%b expected 1/1", running, bus.desc_ready);
    end
  endtask

  task automatic test_swap_random();
    int wb, rb, n;
    bit ok, do_swap;
    logic [31:0] base;
    logic [15:0] w, h;
    exp_q.delete(); rel_exp.delete();
    wb = wr_q.size(); rb = rel_q.size();
    for (int it = 0; it < 8; it++) begin
      case (it)
        0: begin do_swap = 1; base = 32'h2000; w = 16'd8; h = 16'd3; end
        1: begin do_swap = 0; base = 32'h0; w = 16'd1; h = 16'd1; end
        2: begin do_swap = 1; base = $urandom & 32'hFFFF_FFFC; w = 16'd1; h = 16'd1; end
        3: begin do_swap = 1; base = $urandom & 32'hFFFF_FFFC; w = 16'hFFFF; h = 16'hFFFF; end
        default: begin
          do_swap = bit'($urandom_range(0, 1));
          base = $urandom & 32'hFFFF_FFFC;
          w = 16'($urandom_range(1, 2000));
          h = 16'($urandom_range(1, 1200));
        end
      endcase
      if (do_swap) begin
        send_desc(base, w, h, 1'b0, ok);
        model_swap(base, w, h);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL swap_accept%0d: got no accept, expected accept", it); end
        repeat (12) @(negedge clock);
        vectors++;
        if (bus.desc_ready !== 1'b0) begin
          miscompares++; $display("FAIL pending_ready%0d: got %b expected 0", it, bus.desc_ready);
        end
      end
      irq_service(1'b0, ok);
      model_irq();
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL irq_clear%0d: got no clear write, expected (2,1)", it); end
      repeat (4) @(negedge clock);
      vectors++;
      if (bus.desc_ready !== 1'b1) begin
        miscompares++; $display("FAIL after_irq_ready%0d: got %b expected 1", it, bus.desc_ready);
      end
    end
    n = wr_q.size() - wb;
    vectors++;
    if (n != exp_q.size()) begin
      miscompares++; $display("FAIL swap_count: got %0d writes expected %0d", n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (wr_q[wb+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL swap_wr%0d: got (%0d,0x%08h) expected (%0d,0x%08h)", i,
                 wr_q[wb+i][36:32], wr_q[wb+i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    n = rel_q.size() - rb;
    vectors++;
    if (n != rel_exp.size()) begin
      miscompares++; $display("FAIL swap_rel_count: got %0d releases expected %0d", n, rel_exp.size());
    end
    for (int i = 0; i < n && i < rel_exp.size(); i++) begin
      vectors++;
      if (rel_q[rb+i] !== rel_exp[i]) begin
        miscompares++;
        $display("FAIL swap_rel%0d: got 0x%08h expected 0x%08h", i, rel_q[rb+i], rel_exp[i]);
      end
    end
  endtask

  task automatic test_irq_collide();
    int wb, rb, n;
    bit ok;
    logic [31:0] base;
    exp_q.delete(); rel_exp.delete();
    wb = wr_q.size(); rb = rel_q.size();
    base = $urandom & 32'hFFFF_FFFC;
    send_desc(base, 16'd100, 16'd50, 1'b1, ok);
    model_swap(base, 16'd100, 16'd50);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL collide_accept: got no accept, expected accept"); end
    irq_service(1'b1, ok);
    model_irq();
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL collide_clear: got no clear write, expected (2,1)"); end
    repeat (4) @(negedge clock);
    n = wr_q.size() - wb;
    vectors++;
    if (n != exp_q.size()) begin
      miscompares++; $display("FAIL collide_count: got %0d writes expected %0d", n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (wr_q[wb+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL collide_wr%0d: got (%0d,0x%08h) expected (%0d,0x%08h)", i,
                 wr_q[wb+i][36:32], wr_q[wb+i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    n = rel_q.size() - rb;
    vectors++;
    if (n != 1 || rel_q[rb] !== rel_exp[0]) begin
      miscompares++;
      $display("FAIL collide_rel: got %0d releases (first 0x%08h) expected 1 of 0x%08h",
               n, (n > 0) ? rel_q[rb] : 32'h0, rel_exp[0]);
    end
  endtask

  task automatic test_stop();
    int wb, rb, n;
    bit ok;
    logic [31:0] base;
    exp_q.delete(); rel_exp.delete();
    wb = wr_q.size(); rb = rel_q.size();
    base = $urandom & 32'hFFFF_FFFC;
    send_desc(base, 16'd32, 16'd32, 1'b0, ok);
    model_swap(base, 16'd32, 16'd32);
    repeat (12) @(negedge clock);
    stop = 1'b1;
    exp_q.push_back({5'd0, 32'd0});
    m_pending = 0;
    for (int i = 0; i < 10 && running === 1'b1; i++) @(negedge clock);
    stop = 1'b0;
    @(negedge clock);
    vectors++;
    if (running !== 1'b0 || bus.desc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_state: got running=%b ready=%b expected 0/1", running, bus.desc_ready);
    end
    base = $urandom & 32'hFFFF_FFFC;
    send_desc(base, 16'd7, 16'd5, 1'b0, ok);
    model_start(base, 16'd7, 16'd5);
    repeat (14) @(negedge clock);
    vectors++;
    if (!ok || running !== 1'b1) begin
      miscompares++; $display("FAIL restart: got accept=%b running=%b expected 1/1", ok, running);
    end
    n = wr_q.size() - wb;
    vectors++;
    if (n != exp_q.size()) begin
      miscompares++; $display("FAIL stop_count: got %0d writes expected %0d", n, exp_q.size());
    end
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      vectors++;
      if (wr_q[wb+i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stop_wr%0d: got (%0d,0x%08h) expected (%0d,0x%08h)", i,
                 wr_q[wb+i][36:32], wr_q[wb+i][31:0], exp_q[i][36:32], exp_q[i][31:0]);
      end
    end
    vectors++;
    if (rel_q.size() != rb) begin
      miscompares++; $display("FAIL stop_rel: got %0d releases expected 0", rel_q.size() - rb);
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    bit ok, seen;
    send_desc($urandom & 32'hFFFF_FFFC, 16'd64, 16'd64, 1'b0, ok);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (bus.av_write === 1'b1 && bus.av_address >= 5'd11) seen = 1;
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (!seen || bus.av_write !== 1'b0 || running !== 1'b0 || bus.desc_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got seen=%b av_write=%b running=%b ready=%b expected 1/0/0/0",
               seen, bus.av_write, running, bus.desc_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_pending = 0;
    wb = wr_q.size();
    repeat (6) @(negedge clock);
    vectors++;
    if (bus.desc_ready !== 1'b1 || wr_q.size() != wb) begin
      miscompares++;
      $display("FAIL post_reset: got ready=%b writes=%0d expected 1/0", bus.desc_ready, wr_q.size() - wb);
    end
  endtask

`ifdef VFR_BANK_SCHED_STATS_EN
  task automatic test_stats();
    bit ok;
    int irqs, reps;
    irqs = 0; reps = 0;
    send_desc(32'h4000, 16'd4, 16'd4, 1'b0, ok);
    repeat (14) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        send_desc(32'h5000, 16'd4, 16'd4, 1'b0, ok);
        repeat (12) @(negedge clock);
      end else begin
        reps++;
      end
      irq_service(1'b0, ok);
      irqs++;
      repeat (4) @(negedge clock);
    end
    vectors++;
    if (frames_shown !== 16'(irqs) || repeats !== 16'(reps)) begin
      miscompares++;
      $display("FAIL stats: got frames=%0d repeats=%0d expected %0d/%0d",
               frames_shown, repeats, irqs, reps);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_swap_random();
    repeat (3) @(negedge clock);
    test_irq_collide();
    test_stop();
    test_reset_mid();
`ifdef VFR_BANK_SCHED_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
